// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver feeding a line parser that turns "<letter><CR|LF>" into
// one-cycle pet command strobes; raw bytes are exported alongside.
module uart_cmd_rx #(
  parameter int DELAY_FRAMES = 234
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err,
  output logic [2:0] cmd_code,
  output logic       cmd_valid,
  output logic       cmd_err,
  output logic       busy
);
  localparam int HALF_DELAY_WAIT = DELAY_FRAMES / 2;
  localparam logic [12:0] FULL = 13'(DELAY_FRAMES);
  localparam logic [12:0] HALF = 13'(HALF_DELAY_WAIT);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rxState_t;
  typedef enum logic [1:0] {P_EMPTY, P_HAVE, P_BAD} parseState_t;

  logic        rxMeta, rxS;
  rxState_t    state;
  logic [12:0] cnt;
  logic [2:0]  bitIdx;
  logic [7:0]  shift;
  parseState_t pState;
  logic [2:0]  pCode;
  logic [2:0]  byteCode;
  logic        isTerm;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rxMeta <= 1'b1;
      rxS    <= 1'b1;
    end else begin
      rxMeta <= uart_rx;
      rxS    <= rxMeta;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bitIdx     <= '0;
      shift      <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: if (!rxS) begin
          state <= START;
          cnt   <= 13'd1;
        end
        // Start bit must still be low at its midpoint, otherwise it was a glitch
        START: if (cnt == HALF) begin
          if (!rxS) begin
            state  <= DATA;
            cnt    <= 13'd1;
            bitIdx <= '0;
          end else begin
            state <= IDLE;
          end
        end else begin
          cnt <= cnt + 13'd1;
        end
        DATA: if (cnt == FULL) begin
          shift  <= {rxS, shift[7:1]};
          cnt    <= 13'd1;
          bitIdx <= bitIdx + 3'd1;
          if (bitIdx == 3'd7) state <= STOP;
        end else begin
          cnt <= cnt + 13'd1;
        end
        STOP: if (cnt == FULL) begin
          if (rxS) begin
            byte_data  <= shift;
            byte_valid <= 1'b1;
            state      <= IDLE;
          end else begin
            frame_err <= 1'b1;
            state     <= BREAK;
          end
        end else begin
          cnt <= cnt + 13'd1;
        end
        // Held-low line: wait for idle so a break reports only once
        BREAK: if (rxS) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

  always_comb begin
    byteCode = 3'd0;
    case (byte_data | 8'h20)
      8'h66: byteCode = 3'd1;
      8'h70: byteCode = 3'd2;
      8'h73: byteCode = 3'd3;
      8'h63: byteCode = 3'd4;
      8'h74: byteCode = 3'd5;
      default: byteCode = 3'd0;
    endcase
  end

  assign isTerm = (byte_data == 8'h0D) || (byte_data == 8'h0A);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pState    <= P_EMPTY;
      pCode     <= '0;
      cmd_code  <= '0;
      cmd_valid <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      cmd_err   <= 1'b0;
      if (frame_err) begin
        pState <= P_BAD;
      end else if (byte_valid) begin
        if (isTerm) begin
          // Terminator on an empty line is silent so CRLF doesn't double-fire
          if (pState == P_HAVE) begin
            cmd_code  <= pCode;
            cmd_valid <= 1'b1;
          end else if (pState == P_BAD) begin
            cmd_err <= 1'b1;
          end
          pState <= P_EMPTY;
        end else if (pState == P_EMPTY && byteCode != 3'd0) begin
          pState <= P_HAVE;
          pCode  <= byteCode;
        end else begin
          pState <= P_BAD;
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_cmd_rx.sv
// Scoreboard bench for uart_cmd_rx at 16 clocks per bit: expected bytes and
// command results are queued as lines are sent and popped as the DUT pulses.
module tb_uart_cmd_rx;
  localparam int DF = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       uart_rx;
  logic [7:0] byte_data;
  logic       byte_valid, frame_err, cmd_valid, cmd_err, busy;
  logic [2:0] cmd_code;

  uart_cmd_rx #(.DELAY_FRAMES(DF)) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx),
    .byte_data(byte_data), .byte_valid(byte_valid), .frame_err(frame_err),
    .cmd_code(cmd_code), .cmd_valid(cmd_valid), .cmd_err(cmd_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int cyc = 0, lastStartCyc = 0;
  int byteCnt = 0, feCnt = 0, cmdCnt = 0;
  bit latDone = 0;
  logic [7:0] byteQ[$];
  logic [3:0] cmdQ[$];  // {isErr, expected cmd_code}

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (byte_valid || frame_err) chk("bv_fe_excl", 32'(byte_valid & frame_err), 0);
      if (cmd_valid || cmd_err) chk("cv_ce_excl", 32'(cmd_valid & cmd_err), 0);
      if (frame_err) feCnt++;
      if (byte_valid) begin
        byteCnt++;
        if (!latDone) begin
          latDone = 1;
          chk("latency_ok", 32'((cyc - lastStartCyc) >= 154 && (cyc - lastStartCyc) <= 156), 1);
        end
        if (byteQ.size() == 0) chk("unexpected_byte", 32'(byte_data), 32'hFFFF);
        else chk("byte_data", 32'(byte_data), 32'(byteQ.pop_front()));
      end
      if (cmd_valid || cmd_err) begin
        cmdCnt++;
        if (cmdQ.size() == 0) chk("unexpected_cmd", 32'({cmd_err, cmd_code}), 32'hFFFF);
        else chk("cmd_result", 32'({cmd_err, cmd_code}), 32'(cmdQ.pop_front()));
      end
    end
  end

  task automatic sendByte(input logic [7:0] b, input logic stopBit);
    lastStartCyc = cyc;
    uart_rx = 1'b0;
    repeat (DF) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (DF) @(negedge clk);
    end
    uart_rx = stopBit;
    repeat (DF) @(negedge clk);
  endtask

  task automatic sendGood(input logic [7:0] b);
    byteQ.push_back(b);
    sendByte(b, 1'b1);
  endtask

  task automatic idle(input int n);
    uart_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  logic [15:0] allOut;
  assign allOut = {byte_data, byte_valid, frame_err, cmd_code, cmd_valid, cmd_err, busy};

  int b0, f0, c0;

  initial begin
    rst_n = 1'b0;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'(allOut), 0);
    rst_n = 1'b1;
    idle(5);

    // 1: "F\r"
    cmdQ.push_back({1'b0, 3'd1});
    sendGood(8'h46);
    sendGood(8'h0D);
    idle(10);
    chk("t1_cmd_code", 32'(cmd_code), 1);

    // 2: "p\r\n", LF on empty line is silent
    cmdQ.push_back({1'b0, 3'd2});
    sendGood(8'h70);
    sendGood(8'h0D);
    sendGood(8'h0A);
    idle(10);
    chk("t2_cmd_cnt", 32'(cmdCnt), 2);

    // 3: "FX\r" and "?\n" are malformed; code stays 2
    cmdQ.push_back({1'b1, 3'd2});
    cmdQ.push_back({1'b1, 3'd2});
    sendGood(8'h46);
    sendGood(8'h58);
    sendGood(8'h0D);
    sendGood(8'h3F);
    sendGood(8'h0A);
    idle(10);
    chk("t3_cmd_code_held", 32'(cmd_code), 2);
    chk("t3_cmd_cnt", 32'(cmdCnt), 4);

    // 4: short glitch
    b0 = byteCnt; f0 = feCnt;
    uart_rx = 1'b0;
    repeat (5) @(negedge clk);
    idle(3 * DF);
    chk("t4_no_byte", 32'(byteCnt - b0), 0);
    chk("t4_no_fe", 32'(feCnt - f0), 0);
    chk("t4_busy_low", 32'(busy), 0);

    // 5: bad stop bit then held low, then "\r" and "T\r"
    f0 = feCnt;
    sendByte(8'h53, 1'b0);
    uart_rx = 1'b0;
    repeat (40) @(negedge clk);
    chk("t5_busy_in_break", 32'(busy), 1);
    idle(2 * DF);
    chk("t5_one_fe", 32'(feCnt - f0), 1);
    cmdQ.push_back({1'b1, 3'd2});
    sendGood(8'h0D);
    cmdQ.push_back({1'b0, 3'd5});
    sendGood(8'h54);
    sendGood(8'h0D);
    idle(10);
    chk("t5_cmd_code", 32'(cmd_code), 5);

    // 6: reset mid-DATA of 'C' (0x43: bits 1,1,0,...)
    b0 = byteCnt; f0 = feCnt; c0 = cmdCnt;
    uart_rx = 1'b0;
    repeat (DF) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * DF) @(negedge clk);
    uart_rx = 1'b0;
    repeat (DF / 2) @(negedge clk);
    chk("t6_busy_mid_data", 32'(busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_outputs_in_reset", 32'(allOut), 0);
    rst_n = 1'b1;
    uart_rx = 1'b1;
    @(negedge clk);
    chk("t6_outputs_after_reset", 32'(allOut), 0);
    idle(12 * DF);
    chk("t6_no_pulses", 32'((byteCnt - b0) + (feCnt - f0) + (cmdCnt - c0)), 0);
    cmdQ.push_back({1'b0, 3'd4});
    sendGood(8'h43);
    sendGood(8'h0D);
    idle(10);
    chk("t6_cmd_code", 32'(cmd_code), 4);

    chk("byteQ_drained", 32'(byteQ.size()), 0);
    chk("cmdQ_drained", 32'(cmdQ.size()), 0);
    chk("total_bytes", 32'(byteCnt), 15);
    chk("total_fe", 32'(feCnt), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
